remote_cmd_arbiter: RTL and testbench
=====================================

# remote_cmd_arbiter

Round-robin arbiter/sequencer that shares one remote command link (16-bit command out, 8-bit response back over a UART transceiver) between up to NUM_REQ requesters. Sits between the host-side requesters (test sequencer, console, watchdog pinger) and the remote comm unit. Latches the winning requester's command, pulses `send_cmd`, waits for `cmd_sent` and then `resp_rdy`, and routes the response byte back to the winner only. Optional response timeout.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 2_000_000, response timeout in clk cycles (used only with timeout feature)
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  per-requester request; held high until that requester's `done` bit pulses
- req_cmd  in  16*NUM_REQ  commands; requester i at [16*i+15:16*i]; stable while req[i] high
- gnt  out  NUM_REQ  one-hot grant, high from ISSUE through completion
- done  out  NUM_REQ  one-cycle pulse to granted requester at completion
- resp_out  out  8  response byte, valid with `done`, held until next completion
- timeout  out  1  one-cycle pulse with `done` when completion was a timeout
- busy  out  1  high in any state other than IDLE
- send_cmd  out  1  one-cycle start pulse to comm unit
- cmd  out  16  command to comm unit, registered
- cmd_sent  in  1  level from comm unit; cleared by send_cmd, set after second byte
- resp_rdy  in  1  one-cycle pulse, response byte valid
- resp  in  8  response byte from comm unit

## Operation
- States: IDLE, ISSUE, WAIT_SENT, WAIT_RESP.
- IDLE: if any req bit high, select winner round-robin starting at (last_gnt+1) mod NUM_REQ; register gnt, cmd <= req_cmd[winner], last_gnt <= winner; go ISSUE. No req: stay.
- ISSUE: send_cmd=1 for exactly this cycle; go WAIT_SENT.
- WAIT_SENT: advance to WAIT_RESP on rising edge of cmd_sent (registered previous value 0, current 1). A level left high from a prior transaction must not advance.
- WAIT_RESP: on resp_rdy, resp_out <= resp, done[gnt] pulses, gnt clears, go IDLE.
- cmd held constant from ISSUE until return to IDLE.
- Requester dropping req mid-transaction: no abort; transaction completes, done still pulses.
- resp_rdy in IDLE/ISSUE/WAIT_SENT: ignored, resp_out unchanged.
- Only one transaction outstanding; no queuing.
- Reset values: state IDLE, gnt 0, done 0, resp_out 8'h00, timeout 0, busy 0, send_cmd 0, cmd 16'h0000, last_gnt NUM_REQ-1 (so requester 0 wins first). Reset mid-transaction: all of above immediately; in-flight response discarded.

## Timing
- req[i] high in IDLE at cycle t: gnt/cmd valid t+1, send_cmd high in t+1 only, busy high from t+1.
- cmd_sent rising seen at cycle s: WAIT_RESP from s+1.
- resp_rdy at cycle r (in WAIT_RESP): done, resp_out valid r+1; state IDLE at r+1; next grant earliest r+2.
- Fairness: continuously requesting requester waits at most NUM_REQ-1 transactions.
- Completion and new req in same cycle: new req serviced from IDLE next cycle; no bypass.

## Configuration
- REMOTE_ARB_TIMEOUT_EN defined: counter clears on WAIT_RESP entry, increments each WAIT_RESP cycle; when it reaches TIMEOUT_CYC-1 without resp_rdy, go IDLE with done[gnt]=1, timeout=1, resp_out=8'hFF. resp_rdy in the same cycle as expiry wins (normal completion, timeout=0). Counter width $clog2(TIMEOUT_CYC).
- Not defined: no counter; WAIT_RESP waits indefinitely; timeout tied 0.

## Test plan
- Single req[2], req_cmd=16'hA55A -> gnt=4'b0100 and send_cmd one cycle later, cmd=16'hA55A; model returns resp 8'hA5 -> done=4'b0100 one pulse, resp_out=8'hA5.
- All four req high after reset -> grants in order 0,1,2,3,0; each done pulse only on its own bit with its own response.
- Stale cmd_sent=1 held from prior transaction through ISSUE -> no advance until it falls and rises again.
- Stray resp_rdy in IDLE with resp=8'h33 -> resp_out and done unchanged.
- Timeout build, TIMEOUT_CYC=16, no response -> done and timeout pulse 16 cycles after WAIT_RESP entry, resp_out=8'hFF; non-timeout build -> busy stays high.
- rst asserted in WAIT_RESP, then resp_rdy -> all outputs at reset values, no done pulse; next grant goes to requester 0.

Source files
------------

// File: rtl/remote_cmd_arbiter.sv
// remote_cmd_arbiter: round-robin sharing of one remote command link among NUM_REQ requesters
// Ports: clk, rst (async, active-high); req/req_cmd per requester in; gnt/done per requester out;
//        resp_out/timeout with done; busy; send_cmd/cmd to comm unit; cmd_sent/resp_rdy/resp from it.
// Optional build macro REMOTE_ARB_TIMEOUT_EN enables the TIMEOUT_CYC response timeout.
module remote_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [16*NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           resp_out,
  output logic                 timeout,
  output logic                 busy,
  output logic                 send_cmd,
  output logic [15:0]          cmd,
  input  logic                 cmd_sent,
  input  logic                 resp_rdy,
  input  logic [7:0]           resp
);
  localparam int LW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SENT, WAIT_RESP} state_t;
  state_t state, next_state;
  logic [LW-1:0] last_gnt, winner, idx;
  logic cmd_sent_q, expire, complete;
  // Descending scan so the requester nearest after last_gnt is assigned last and wins.
  always_comb begin
    winner = last_gnt;
    idx = last_gnt;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = LW'((int'(last_gnt) + k) % NUM_REQ);
      if (req[idx]) winner = idx;
    end
  end
`ifdef REMOTE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  // Held at zero outside WAIT_RESP, so it reads zero on the first WAIT_RESP cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state == WAIT_RESP) ? cnt + 1'b1 : '0;
  assign expire = (state == WAIT_RESP) && (cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign expire = 1'b0;
`endif
  assign complete = (state == WAIT_RESP) && (resp_rdy || expire);
  assign send_cmd = (state == ISSUE);
  assign busy = (state != IDLE);
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      next_state = |req ? ISSUE : IDLE;
      ISSUE:     next_state = WAIT_SENT;
      // Only a fresh rising edge counts; a level left high from before is ignored.
      WAIT_SENT: next_state = (cmd_sent && !cmd_sent_q) ? WAIT_RESP : WAIT_SENT;
      WAIT_RESP: next_state = complete ? IDLE : WAIT_RESP;
      default:   next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt        <= '0;
      done       <= '0;
      resp_out   <= 8'h00;
      timeout    <= 1'b0;
      cmd        <= 16'h0000;
      last_gnt   <= LW'(NUM_REQ - 1);
      cmd_sent_q <= 1'b0;
    end else begin
      cmd_sent_q <= cmd_sent;
      done       <= '0;
      timeout    <= 1'b0;
      if (state == IDLE && |req) begin
        gnt      <= NUM_REQ'(1) << winner;
        cmd      <= req_cmd[16*int'(winner) +: 16];
        last_gnt <= winner;
      end
      if (complete) begin
        done     <= gnt;
        gnt      <= '0;
        resp_out <= resp_rdy ? resp : 8'hFF;
        timeout  <= !resp_rdy;
      end
    end
endmodule

// File: tb/tb_remote_cmd_arbiter.sv
// tb_remote_cmd_arbiter: directed vector bench for remote_cmd_arbiter
module tb_remote_cmd_arbiter;
  localparam int N = 4;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0;
  logic [16*N-1:0] req_cmd = {16'h4444, 16'hA55A, 16'h2222, 16'h1111};
  logic [N-1:0] gnt, done;
  logic [7:0] resp_out, resp = 8'h00;
  logic timeout, busy, send_cmd, cmd_sent = 0, resp_rdy = 0;
  logic [15:0] cmd;
  int passed = 0, total = 0;
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [15:0] cmd;
    logic [7:0]  resp;
  } vec_t;
  vec_t vt[9];
  remote_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .gnt(gnt), .done(done),
    .resp_out(resp_out), .timeout(timeout), .busy(busy), .send_cmd(send_cmd), .cmd(cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic run_txn(input vec_t v);
    req = v.req;
    @(negedge clk);
    chk("issue_gnt", 32'(gnt), 32'(v.gnt));
    chk("issue_cmd", 32'(cmd), 32'(v.cmd));
    chk("issue_send", 32'(send_cmd), 1);
    chk("issue_busy", 32'(busy), 1);
    chk("issue_done", 32'(done), 0);
    cmd_sent = 0;
    @(negedge clk);
    chk("send_once", 32'(send_cmd), 0);
    chk("cmd_held", 32'(cmd), 32'(v.cmd));
    cmd_sent = 1;
    @(negedge clk);
    resp = v.resp;
    resp_rdy = 1;
    @(negedge clk);
    resp_rdy = 0;
    req = '0;
    chk("done", 32'(done), 32'(v.gnt));
    chk("resp_out", 32'(resp_out), 32'(v.resp));
    chk("timeout_lo", 32'(timeout), 0);
    chk("gnt_clr", 32'(gnt), 0);
    chk("idle", 32'(busy), 0);
  endtask
  task automatic to_wait_resp(input logic [3:0] r, input logic [3:0] g);
    req = r;
    @(negedge clk);
    chk("wr_gnt", 32'(gnt), 32'(g));
    req = '0;
    cmd_sent = 0;
    @(negedge clk);
    cmd_sent = 1;
    @(negedge clk);
  endtask
  initial begin
    vt[0] = '{4'b1111, 4'b0001, 16'h1111, 8'h10};
    vt[1] = '{4'b1111, 4'b0010, 16'h2222, 8'h21};
    vt[2] = '{4'b1111, 4'b0100, 16'hA55A, 8'h32};
    vt[3] = '{4'b1111, 4'b1000, 16'h4444, 8'h43};
    vt[4] = '{4'b1111, 4'b0001, 16'h1111, 8'h54};
    vt[5] = '{4'b0100, 4'b0100, 16'hA55A, 8'hA5};
    vt[6] = '{4'b1010, 4'b1000, 16'h4444, 8'h6B};
    vt[7] = '{4'b0011, 4'b0001, 16'h1111, 8'h7C};
    vt[8] = '{4'b0110, 4'b0010, 16'h2222, 8'h8D};
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_resp_out", 32'(resp_out), 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) run_txn(vt[i]);
    resp = 8'h33;
    resp_rdy = 1;
    @(negedge clk);
    resp_rdy = 0;
    chk("stray_resp_out", 32'(resp_out), 32'h8D);
    chk("stray_done", 32'(done), 0);
    chk("stray_busy", 32'(busy), 0);
    req = 4'b0001;
    @(negedge clk);
    chk("stale_gnt", 32'(gnt), 32'b0001);
    req = '0;
    @(negedge clk);
    resp = 8'h77;
    resp_rdy = 1;
    @(negedge clk);
    resp_rdy = 0;
    chk("stale_no_done", 32'(done), 0);
    chk("stale_resp_out", 32'(resp_out), 32'h8D);
    chk("stale_busy", 32'(busy), 1);
    cmd_sent = 0;
    @(negedge clk);
    cmd_sent = 1;
    @(negedge clk);
    resp = 8'h5C;
    resp_rdy = 1;
    @(negedge clk);
    resp_rdy = 0;
    chk("drop_done", 32'(done), 32'b0001);
    chk("drop_resp_out", 32'(resp_out), 32'h5C);
    to_wait_resp(4'b0100, 4'b0100);
`ifdef REMOTE_ARB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) chk("to_early", 32'(done), 0);
    end
    chk("to_done", 32'(done), 32'b0100);
    chk("to_flag", 32'(timeout), 1);
    chk("to_resp_out", 32'(resp_out), 32'hFF);
    @(negedge clk);
    chk("to_pulse", 32'(timeout), 0);
    to_wait_resp(4'b1000, 4'b1000);
`else
    repeat (40) @(negedge clk);
    chk("hang_busy", 32'(busy), 1);
    chk("hang_done", 32'(done), 0);
    chk("hang_timeout", 32'(timeout), 0);
`endif
    rst = 1;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cmd", 32'(cmd), 0);
    chk("arst_resp_out", 32'(resp_out), 0);
    chk("arst_send", 32'(send_cmd), 0);
    @(negedge clk);
    rst = 0;
    resp = 8'hEE;
    resp_rdy = 1;
    @(negedge clk);
    resp_rdy = 0;
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_resp_out", 32'(resp_out), 0);
    chk("post_rst_timeout", 32'(timeout), 0);
    run_txn('{4'b1111, 4'b0001, 16'h1111, 8'h99});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
